// File: rtl/vx_tc_tile_buf_pkg.sv
// Shared constants for the tensor-core operand tile buffer: bank states and
// default tile geometry.
package vx_tc_tile_buf_pkg;

  localparam int unsigned TC_TILE_ROWS = 4;
  localparam int unsigned TC_NUM_LANES = 4;

  localparam logic [1:0] BANK_EMPTY   = 2'd0;
  localparam logic [1:0] BANK_FILLING = 2'd1;
  localparam logic [1:0] BANK_FULL    = 2'd2;

endpackage

// File: rtl/vx_tc_tile_buf_bank.sv
// One ping-pong tile bank: row storage, captured tag and EMPTY/FILLING/FULL state.
// Row data and tag are not reset; they are only meaningful once the bank is FULL.
module vx_tc_tile_buf_bank
  import vx_tc_tile_buf_pkg::*;
#(
  parameter int unsigned NUM_LANES  = TC_NUM_LANES,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TILE_ROWS  = TC_TILE_ROWS,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned ROW_CNT_W  = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  wr_en,
  input  logic [ROW_CNT_W-1:0]                  wr_row,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]       wr_data,
  input  logic [TAG_WIDTH-1:0]                  wr_tag,
  input  logic                                  rd_pop,
  output logic [1:0]                            state,
  output logic [TILE_ROWS*NUM_LANES*DATA_WIDTH-1:0] tile_data,
  output logic [TAG_WIDTH-1:0]                  tile_tag
);

  localparam int unsigned ROW_W = NUM_LANES * DATA_WIDTH;

  logic [1:0]                       state_q, state_d;
  logic [TILE_ROWS-1:0][ROW_W-1:0]  data_q, data_d;
  logic [TAG_WIDTH-1:0]             tag_q, tag_d;
  logic                             wr_last;

  assign wr_last = (wr_row == ROW_CNT_W'(TILE_ROWS - 1));

  // A write only ever targets a non-FULL bank and a pop only a FULL one,
  // so the two never collide within this bank.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (clear) begin
      state_d = BANK_EMPTY;
    end else begin
      if (wr_en) begin
        state_d        = wr_last ? BANK_FULL : BANK_FILLING;
        data_d[wr_row] = wr_data;
        if (wr_row == '0) begin
          tag_d = wr_tag;
        end
      end
      if (rd_pop) begin
        state_d = BANK_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BANK_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  assign state     = state_q;
  assign tile_data = data_q;
  assign tile_tag  = tag_q;

endmodule

// File: rtl/vx_tc_tile_buf.sv
// Ping-pong operand tile buffer: collects TILE_ROWS row beats into a tile and
// presents whole tiles to the PE group. Define TC_TILE_BUF_PERF_EN for perf_stall_cycles.
module vx_tc_tile_buf
  import vx_tc_tile_buf_pkg::*;
#(
  parameter int unsigned NUM_LANES  = TC_NUM_LANES,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TILE_ROWS  = TC_TILE_ROWS,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]           in_data,
  input  logic [TAG_WIDTH-1:0]                      in_tag,
  input  logic                                      flush,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [TILE_ROWS*NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]                      out_tag
`ifdef TC_TILE_BUF_PERF_EN
  ,
  output logic [31:0]                               perf_stall_cycles
`endif
);

  localparam int unsigned ROW_W     = NUM_LANES * DATA_WIDTH;
  localparam int unsigned TILE_W    = TILE_ROWS * ROW_W;
  localparam int unsigned ROW_CNT_W = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [ROW_CNT_W-1:0] row_q, row_d;

  logic [1:0]           bank_state [2];
  logic [TILE_W-1:0]    bank_data  [2];
  logic [TAG_WIDTH-1:0] bank_tag   [2];
  logic [1:0]           bank_wr_en;
  logic [1:0]           bank_rd_pop;

  logic accept;
  logic drain;
  logic last_row;

  assign in_ready  = !reset && (bank_state[wr_ptr_q] != BANK_FULL) && !flush;
  assign out_valid = (bank_state[rd_ptr_q] == BANK_FULL);
  assign out_data  = bank_data[rd_ptr_q];
  assign out_tag   = bank_tag[rd_ptr_q];

  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign last_row = (row_q == ROW_CNT_W'(TILE_ROWS - 1));

  // in_ready already excludes flush, so only the drain needs masking here.
  assign bank_wr_en  = {accept && wr_ptr_q, accept && !wr_ptr_q};
  assign bank_rd_pop = {drain && !flush && rd_ptr_q, drain && !flush && !rd_ptr_q};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    row_d    = row_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      row_d    = '0;
    end else begin
      if (accept) begin
        if (last_row) begin
          row_d    = '0;
          wr_ptr_d = !wr_ptr_q;
        end else begin
          row_d = row_q + ROW_CNT_W'(1);
        end
      end
      if (drain) begin
        rd_ptr_d = !rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      row_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      row_q    <= row_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    vx_tc_tile_buf_bank #(
      .NUM_LANES  (NUM_LANES),
      .DATA_WIDTH (DATA_WIDTH),
      .TILE_ROWS  (TILE_ROWS),
      .TAG_WIDTH  (TAG_WIDTH),
      .ROW_CNT_W  (ROW_CNT_W)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .wr_en     (bank_wr_en[b]),
      .wr_row    (row_q),
      .wr_data   (in_data),
      .wr_tag    (in_tag),
      .rd_pop    (bank_rd_pop[b]),
      .state     (bank_state[b]),
      .tile_data (bank_data[b]),
      .tile_tag  (bank_tag[b])
    );
  end

`ifdef TC_TILE_BUF_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where upstream offers a beat we cannot take.
  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vx_tc_tile_buf.sv
// Bench for vx_tc_tile_buf: directed scenarios plus random traffic checked
// against a tile-queue reference model.
module tb_vx_tc_tile_buf;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned TILE_ROWS  = 4;
  localparam int unsigned TAG_WIDTH  = 8;
  localparam int unsigned ROW_W      = NUM_LANES * DATA_WIDTH;
  localparam int unsigned TILE_W     = TILE_ROWS * ROW_W;

  typedef struct packed {
    logic [TILE_W-1:0]    data;
    logic [TAG_WIDTH-1:0] tag;
  } tile_t;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROW_W-1:0]     in_data;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [TILE_W-1:0]    out_data;
  logic [TAG_WIDTH-1:0] out_tag;
`ifdef TC_TILE_BUF_PERF_EN
  logic [31:0]          perf_stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: completed tiles in arrival order plus the partial tile.
  tile_t                mq[$];
  logic [TILE_W-1:0]    m_pdata;
  logic [TAG_WIDTH-1:0] m_ptag;
  int                   m_rows;
  logic [31:0]          m_stall;

  vx_tc_tile_buf #(
    .NUM_LANES  (NUM_LANES),
    .DATA_WIDTH (DATA_WIDTH),
    .TILE_ROWS  (TILE_ROWS),
    .TAG_WIDTH  (TAG_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef TC_TILE_BUF_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [TILE_W-1:0] obs, input logic [TILE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rnd_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < int'(ROW_W / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] pat_row(input logic [7:0] b);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < int'(ROW_W / 8); i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  // One clock: drive at negedge, compare to model, then advance model at posedge.
  task automatic cycle(input logic v, input logic [ROW_W-1:0] d, input logic [TAG_WIDTH-1:0] t,
                       input logic ordy, input logic fl);
    logic  exp_rdy, exp_ov, acc, drn;
    tile_t nt;
    @(negedge clk);
    in_valid = v; in_data = d; in_tag = t; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (mq.size() < 2);
    exp_ov  = (mq.size() > 0);
    chk("in_ready", TILE_W'(in_ready), TILE_W'(exp_rdy));
    chk("out_valid", TILE_W'(out_valid), TILE_W'(exp_ov));
    if (exp_ov) begin
      chk("out_data", out_data, mq[0].data);
      chk("out_tag", TILE_W'(out_tag), TILE_W'(mq[0].tag));
    end
`ifdef TC_TILE_BUF_PERF_EN
    chk("perf_stall", TILE_W'(perf_stall_cycles), TILE_W'(m_stall));
`endif
    acc = v && exp_rdy;
    drn = exp_ov && ordy;
    @(posedge clk);
    if (v && !exp_rdy && (m_stall != 32'hFFFF_FFFF)) m_stall++;
    if (fl) begin
      mq.delete();
      m_rows = 0;
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) begin
        if (m_rows == 0) m_ptag = t;
        m_pdata[m_rows*ROW_W +: ROW_W] = d;
        m_rows++;
        if (m_rows == int'(TILE_ROWS)) begin
          nt.data = m_pdata;
          nt.tag  = m_ptag;
          mq.push_back(nt);
          m_rows = 0;
        end
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, rnd_row(), 8'h00, ordy, 1'b0);
  endtask

  initial begin
    logic [TILE_W-1:0] exp_tile;
    m_rows = 0; m_stall = '0; m_pdata = '0; m_ptag = '0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", TILE_W'(in_ready), TILE_W'(1'b0));
    chk("rst_out_valid", TILE_W'(out_valid), TILE_W'(1'b0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single tile, rows 0x11..0x44, tag 0x5A
    cycle(1'b1, pat_row(8'h11), 8'h5A, 1'b1, 1'b0);
    cycle(1'b1, pat_row(8'h22), 8'h00, 1'b1, 1'b0);
    cycle(1'b1, pat_row(8'h33), 8'h00, 1'b1, 1'b0);
    cycle(1'b1, pat_row(8'h44), 8'h00, 1'b1, 1'b0);
    #2;
    exp_tile = {pat_row(8'h44), pat_row(8'h33), pat_row(8'h22), pat_row(8'h11)};
    chk("single_valid", TILE_W'(out_valid), TILE_W'(1'b1));
    chk("single_data", out_data, exp_tile);
    chk("single_tag", TILE_W'(out_tag), TILE_W'(8'h5A));
    idle(1'b1);
    #2;
    chk("single_empty", TILE_W'(out_valid), TILE_W'(1'b0));

    // Backpressure: 8 beats fill both banks, then further beats stall
    for (int i = 0; i < 12; i++) cycle(1'b1, rnd_row(), TAG_WIDTH'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Streaming, one tile per TILE_ROWS cycles, tags 1,2,3
    for (int i = 0; i < 12; i++) cycle(1'b1, rnd_row(), TAG_WIDTH'(i / 4 + 1), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush while tile 0 is FULL and tile 1 holds 2 rows
    for (int i = 0; i < 6; i++) cycle(1'b1, rnd_row(), (i < 4) ? 8'h10 : 8'h20, 1'b0, 1'b0);
    cycle(1'b1, rnd_row(), 8'h99, 1'b1, 1'b1);
    #2;
    chk("flush_out_valid", TILE_W'(out_valid), TILE_W'(1'b0));
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_row(), 8'h30, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Tag changes on rows 1..3 are ignored
    cycle(1'b1, rnd_row(), 8'h77, 1'b0, 1'b0);
    cycle(1'b1, rnd_row(), 8'h01, 1'b0, 1'b0);
    cycle(1'b1, rnd_row(), 8'h02, 1'b0, 1'b0);
    cycle(1'b1, rnd_row(), 8'h03, 1'b0, 1'b0);
    #2;
    chk("tag_row0", TILE_W'(out_tag), TILE_W'(8'h77));
    idle(1'b1);

    // Asynchronous reset mid-cycle during row 2 of tile 1, tile 0 FULL
    for (int i = 0; i < 6; i++) cycle(1'b1, rnd_row(), 8'h40, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("areset_out_valid", TILE_W'(out_valid), TILE_W'(1'b0));
    chk("areset_in_ready", TILE_W'(in_ready), TILE_W'(1'b0));
    mq.delete(); m_rows = 0; m_stall = '0;
`ifdef TC_TILE_BUF_PERF_EN
    chk("areset_perf", TILE_W'(perf_stall_cycles), TILE_W'(0));
`endif
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_row(), 8'hC3, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd_row(), TAG_WIDTH'($urandom()),
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_tc_tile_buf.md
VX_TC_TILE_BUF -- requirements
Module: VX_tc_tile_buf

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: operand elements per dispatch beat (one per thread).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per element.
REQ-003 SHALL have parameter TILE_ROWS, default 4: beats per tile; at least 2.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: bits of the warp/instruction tag carried with a tile.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the input row beat is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a row beat.
REQ-009 SHALL have port in_data, input, NUM_LANES*DATA_WIDTH bits: one tile row; lane 0 is in the LSBs.
REQ-010 SHALL have port in_tag, input, TAG_WIDTH bits: tag, sampled on the first row of a tile only.
REQ-011 SHALL have port flush, input, 1 bit: synchronous discard of all buffered and partial tiles.
REQ-012 SHALL have port out_valid, output, 1 bit: a complete tile is presented.
REQ-013 SHALL have port out_ready, input, 1 bit: the downstream PE group accepts the tile.
REQ-014 SHALL have port out_data, output, TILE_ROWS*NUM_LANES*DATA_WIDTH bits: the whole tile; row 0 is in the LSBs.
REQ-015 SHALL have port out_tag, output, TAG_WIDTH bits: the tag of the presented tile.

Function
REQ-016 SHALL contain two tile banks (ping-pong); each bank is in state EMPTY, FILLING or FULL.
REQ-017 SHALL write to one write-bank pointer; a beat is accepted when in_valid&&in_ready.
REQ-018 SHALL move a bank EMPTY->FILLING on an accepted beat with row counter 0; this latches in_tag.
REQ-019 SHALL store each accepted beat at row index = row counter, then increment the counter.
REQ-020 SHALL, on an accepted beat with row counter TILE_ROWS-1, move the bank to FULL, wrap the counter to 0 and toggle the write pointer.
REQ-021 SHALL drive in_ready = (write bank != FULL) && !flush.
REQ-022 SHALL have a read pointer; out_valid = (read bank == FULL). out_data and out_tag come directly from register storage, with no combinational path from any input.
REQ-023 SHALL have a latency of one cycle: when the last row is accepted at edge N, out_valid is high after edge N.
REQ-024 SHALL, on out_valid&&out_ready, move the read bank to EMPTY and toggle the read pointer.
REQ-025 SHALL hold out_data and out_tag stable while out_valid is high and out_ready is low.
REQ-026 SHALL allow both banks to be FULL; in that state in_ready=0, and out_valid stays 1.
REQ-027 SHALL make a simultaneous last-row write to one bank and a drain of the other take effect in the same cycle, with no bubble; sustained throughput is one tile per TILE_ROWS cycles.
REQ-028 SHALL allow a single bank to be drained and refilled at the same edge only across banks, never within the same bank.
REQ-029 SHALL make flush, at the next edge, set both banks to EMPTY, both pointers to 0 and the row counter to 0; flush takes priority over a simultaneous accept or drain.
REQ-030 SHALL leave in_tag ignored on rows other than row 0.

Reset
REQ-031 SHALL, on reset assertion, immediately set: both banks EMPTY; pointers 0; row counter 0; out_valid=0; in_ready=0 while reset is high, then 1 after release.
REQ-032 SHALL leave tile data storage unreset; out_data is don't-care while out_valid=0.
REQ-033 SHALL make reset mid-tile discard the partial tile; the first beat after release is row 0 of a new tile.

Configuration
REQ-034 SHALL, with macro TC_TILE_BUF_PERF_EN defined, add output perf_stall_cycles (32 bits); it increments each cycle in_valid&&!in_ready, saturates at all-ones, is cleared by reset, and is not cleared by flush.
REQ-035 SHALL, without TC_TILE_BUF_PERF_EN, omit the port and the counter logic; all other behaviour is identical.

Structure
REQ-036 SHALL define the bank state enum (EMPTY/FILLING/FULL) and TC_TILE_ROWS/TC_NUM_LANES defaults in VX_gpu_pkg.
REQ-037 SHALL implement one bank (storage, state, tag) as sub-module VX_tc_tile_bank, instantiated twice.

Verification
REQ-038 SHALL check a single tile: 4 beats with rows 0x11..,0x22..,0x33..,0x44.. and tag 0x5A, out_ready=1 -> out_valid one cycle after beat 4, out_data rows in order, out_tag=0x5A, then EMPTY.
REQ-039 SHALL check backpressure: out_ready=0 while 8 beats are sent -> in_ready drops after beat 8, beat 9 stalls, perf_stall_cycles counts the stall cycles, data stays stable.
REQ-040 SHALL check streaming: in_valid=1 continuously, out_ready=1 -> in_ready never drops, one tile every 4 cycles, tags 1,2,3 in order.
REQ-041 SHALL check flush after 2 rows of tile 1 while tile 0 is FULL -> out_valid=0 next cycle, the next 4 beats form a new tile with the new tag.
REQ-042 SHALL check reset asserted asynchronously mid-cycle during row 2 -> out_valid=0 immediately, and the next tile after release is correct.
REQ-043 SHALL check a tag change on rows 1..3 -> out_tag still equals the row-0 tag.
